inst_feeder: RTL
================

INST_FEEDER -- requirements
Module: inst_feeder

Interface
REQ-001 Parameter IW, default 32: instruction width in bits.
REQ-002 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter GW, default 3: width of the gap configuration.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 wr_valid  in  1  load request.
REQ-007 wr_data  in  IW  instruction to enqueue.
REQ-008 wr_ready  out  1  high when count < DEPTH.
REQ-009 run  in  1  issue enable.
REQ-010 flush  in  1  synchronous clear of queue and issue state.
REQ-011 cfg_gap  in  GW  NOP cycles inserted after each issued instruction.
REQ-012 inst  out  IW  registered instruction to the cpu inst port.
REQ-013 inst_valid  out  1  high when inst holds a dequeued instruction, not a NOP.
REQ-014 count  out  $clog2(DEPTH)+1  current occupancy.
REQ-015 issued  out  16  count of issued instructions; wraps 0xFFFF->0.
REQ-016 ovf  out  1  sticky flag, set on wr_valid && !wr_ready.

Function
REQ-017 Enqueue SHALL occur on the rising edge with wr_valid && wr_ready; a write while full SHALL be dropped and set ovf.
REQ-018 There SHALL be no fall-through: a word written into an empty queue SHALL be issuable no earlier than the following edge.
REQ-019 wr_ready SHALL derive from the registered count only; a pop in the same cycle SHALL NOT raise wr_ready while full.
REQ-020 A simultaneous push and pop SHALL leave count unchanged and preserve FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-021 The FSM SHALL have three states: IDLE, ISSUE and GAP.
REQ-022 Issue decision (taken in IDLE, in ISSUE with zero latched gap, and in GAP with gap_cnt==1): if run && count!=0, then pop head into inst, set inst_valid=1, increment issued, latch cfg_gap, and go to ISSUE; otherwise inst=NOP, inst_valid=0, go to IDLE.
REQ-023 In ISSUE with nonzero latched gap: inst=NOP, inst_valid=0, gap_cnt=latched gap, go to GAP.
REQ-024 In GAP with gap_cnt>1: decrement gap_cnt and hold NOP. Exactly latched-gap NOP cycles SHALL separate consecutive valid instructions.
REQ-025 With cfg_gap=0 and a non-empty queue, one valid instruction SHALL issue per cycle, back-to-back.
REQ-026 cfg_gap changes SHALL take effect only at the next issue.
REQ-027 Deasserting run SHALL NOT abort a GAP; its effect appears at the next issue decision.
REQ-028 On flush: count=0, pointers=0, state=IDLE, inst=NOP, inst_valid=0 at that edge. flush SHALL override a same-cycle write, and no ovf SHALL be set. issued and ovf SHALL be retained.
REQ-029 NOP SHALL be all-zero (sll $0,$0,0).

Reset
REQ-030 While reset_n=0: inst=NOP, inst_valid=0, count=0, issued=0, ovf=0, state=IDLE, pointers=0, gap_cnt=0. Queue contents are don't-care.
REQ-031 Reset mid-GAP or mid-stream SHALL discard all pending instructions; the first edge after release SHALL behave as IDLE.

Structure
REQ-032 NOP_INST and feeder_state_t (IDLE, ISSUE, GAP) SHALL live in the shared AluCtrlSig_pkg, next to the opcode and register constants.
REQ-033 Storage SHALL be one sub-module, sync_fifo (parameters IW, DEPTH), instantiated once; the FSM, gap counter and issued counter SHALL reside in inst_feeder.

Verification
REQ-034 Scenario 1 (back-to-back): load 0x00421006, 0x00631806, 0x2042000A with run=1 and cfg_gap=0. Required: the three words appear on consecutive cycles with inst_valid=1, then NOP; issued=3.
REQ-035 Scenario 2 (gap): same load with cfg_gap=4. Required: exactly 4 NOP cycles between each valid instruction; issued=3.
REQ-036 Scenario 3 (full): write DEPTH+1 words with run=0. Required: wr_ready=0 after 8 writes, count=8, ovf=1; the 9th word is never issued.
REQ-037 Scenario 4 (flush): flush with count=5 plus a same-cycle write. Required: count=0, inst=NOP next cycle, ovf unchanged.
REQ-038 Scenario 5 (reset mid-gap): assert reset_n=0 during GAP with 3 words queued. Required: all outputs at reset values; nothing issues after release until new writes.
REQ-039 Scenario 6 (wrap): issue 0x10002 instructions. Required: issued=2, with pointer wrap exercised and FIFO order preserved.

Source files
------------

// File: rtl/AluCtrlSig_pkg.sv
// AluCtrlSig_pkg
// Shared constants for the small MIPS-like core and its instruction feeder:
// primary opcodes, ALU function codes, architectural register numbers, the
// canonical NOP encoding and the feeder's FSM state type.
package AluCtrlSig_pkg;

  // Primary opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instruction bits [5:0])
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;

  // Architectural register numbers
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_AT   = 5'd1;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

  // sll $0,$0,0 encodes as all zeros; this is what the core sees when the
  // feeder has nothing to issue.
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Feeder issue FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/inst_feeder_sync_fifo.sv
// sync_fifo
// Single-clock FIFO holding instructions for the feeder. The head entry is
// presented combinationally on rd_data; it is only meaningful when count != 0.
// A word written into an empty FIFO becomes visible at the head after the
// write edge, so there is no fall-through path from wr_data to rd_data.
//
// Ports:
//   clk, reset_n   clock / async active-low reset
//   flush          synchronous clear of pointers and count (wins over push/pop)
//   push, wr_data  enqueue request and data (ignored when full)
//   pop            dequeue request (ignored when empty)
//   rd_data        current head entry
//   count          registered occupancy, 0..DEPTH
module sync_fifo
  import AluCtrlSig_pkg::*;
#(
  parameter int IW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [IW-1:0]          wr_data,
  input  logic                   pop,
  output logic [IW-1:0]          rd_data,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [IW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  // Guard against misuse at the boundaries; flush suppresses both sides.
  assign push_ok = push && (count_q != FULL) && !flush;
  assign pop_ok  = pop && (count_q != '0) && !flush;

  // Pointers are AW bits wide and DEPTH is a power of two, so the natural
  // overflow of the increment is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset: contents are only read below count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/inst_feeder.sv
// inst_feeder
// Queues instructions loaded by a host and issues them, one per decision,
// onto the registered cpu inst port. After every issued instruction it
// inserts a configurable number of NOP cycles (cfg_gap, latched at issue).
//
// Handshake: a load transfers on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on the registered occupancy (count < DEPTH), never on
// a same-cycle pop. wr_valid while !wr_ready drops the word and sets the
// sticky ovf flag. flush overrides any same-cycle load and never sets ovf.
//
// Ports:
//   clk, reset_n          clock / async active-low reset
//   wr_valid, wr_data     load request and instruction
//   wr_ready              load can be accepted
//   run                   issue enable, sampled at each issue decision
//   flush                 synchronous clear of queue and issue state
//   cfg_gap               NOP cycles after each issued instruction
//   inst, inst_valid      registered instruction (NOP = 0 when not valid)
//   count                 queue occupancy
//   issued                issued-instruction counter (wraps at 16 bits)
//   ovf                   sticky overflow flag
//   dbg_state             current issue FSM state (feeder_state_t encoding)
module inst_feeder
  import AluCtrlSig_pkg::*;
#(
  parameter int IW    = 32,
  parameter int DEPTH = 8,
  parameter int GW    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  input  logic [IW-1:0]          wr_data,
  output logic                   wr_ready,
  input  logic                   run,
  input  logic                   flush,
  input  logic [GW-1:0]          cfg_gap,
  output logic [IW-1:0]          inst,
  output logic                   inst_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic [15:0]            issued,
  output logic                   ovf,
  output logic [1:0]             dbg_state
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [IW-1:0] NOP  = IW'(NOP_INST);

  feeder_state_t state_q, state_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [GW-1:0] gap_lat_q, gap_lat_d;
  logic [IW-1:0] inst_q, inst_d;
  logic          inst_valid_q, inst_valid_d;
  logic [15:0]   issued_q, issued_d;
  logic          ovf_q, ovf_d;

  logic [CW-1:0] fifo_count;
  logic [IW-1:0] fifo_head;
  logic          push, pop, decide;

  assign wr_ready = (fifo_count < FULL);
  assign push     = wr_valid && wr_ready && !flush;
  assign ovf_d    = ovf_q | (wr_valid && !wr_ready && !flush);

  sync_fifo #(
    .IW    (IW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .count   (fifo_count)
  );

  // Next-state / output logic. "decide" marks the cycles in which a new
  // instruction may be issued; everything else holds NOP.
  always_comb begin
    state_d      = state_q;
    gap_cnt_d    = gap_cnt_q;
    gap_lat_d    = gap_lat_q;
    inst_d       = NOP;
    inst_valid_d = 1'b0;
    issued_d     = issued_q;
    pop          = 1'b0;
    decide       = 1'b0;

    if (flush) begin
      state_d   = IDLE;
      gap_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: decide = 1'b1;
        ISSUE: begin
          if (gap_lat_q == '0) begin
            decide = 1'b1;
          end else begin
            // This cycle is the first NOP of the gap; GAP supplies the rest.
            gap_cnt_d = gap_lat_q;
            state_d   = GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q > GW'(1)) gap_cnt_d = gap_cnt_q - GW'(1);
          else                    decide    = 1'b1;
        end
        default: state_d = IDLE;
      endcase

      if (decide) begin
        gap_cnt_d = '0;
        if (run && (fifo_count != '0)) begin
          pop          = 1'b1;
          inst_d       = fifo_head;
          inst_valid_d = 1'b1;
          issued_d     = issued_q + 16'd1;
          gap_lat_d    = cfg_gap;
          state_d      = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gap_cnt_q    <= '0;
      gap_lat_q    <= '0;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
      issued_q     <= '0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_cnt_q    <= gap_cnt_d;
      gap_lat_q    <= gap_lat_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      issued_q     <= issued_d;
      ovf_q        <= ovf_d;
    end
  end

  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign count      = fifo_count;
  assign issued     = issued_q;
  assign ovf        = ovf_q;
  assign dbg_state  = state_q;

endmodule
